lfsr_gen: RTL and testbench

Parametrised XNOR Fibonacci LFSR for pseudo-random sequences, scramblers and test-pattern sources in the CPU and peripherals.
- Generalises the fixed 17-bit generator: any width 3..32, taps chosen from a maximal-length table, and 1..8 bits advanced per enable.
- Adds seed load, a wrap (period-complete) indication and optional lock-up recovery.

---
 rtl/lfsr_pkg.sv | 48 ++++
 rtl/lfsr_gen_if.sv | 27 ++
 rtl/lfsr_step.sv | 19 +
 rtl/lfsr_gen.sv | 114 +++++++++++
 tb/tb_lfsr_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR Fibonacci LFSR generator: width limits,
// the per-enable step limit and the maximal-length tap table.
package lfsr_pkg;

  localparam int unsigned LFSR_MIN_WID  = 3;
  localparam int unsigned LFSR_MAX_WID  = 32;
  localparam int unsigned LFSR_MAX_STEP = 8;

  // Maximal-length XNOR tap sets; tap n maps to mask bit n-1.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] mask;
    case (width)
      3:       mask = 32'h0000_0006;  // 3,2
      4:       mask = 32'h0000_000C;  // 4,3
      5:       mask = 32'h0000_0014;  // 5,3
      6:       mask = 32'h0000_0030;  // 6,5
      7:       mask = 32'h0000_0060;  // 7,6
      8:       mask = 32'h0000_00B8;  // 8,6,5,4
      9:       mask = 32'h0000_0110;  // 9,5
      10:      mask = 32'h0000_0240;  // 10,7
      11:      mask = 32'h0000_0500;  // 11,9
      12:      mask = 32'h0000_0829;  // 12,6,4,1
      13:      mask = 32'h0000_100D;  // 13,4,3,1
      14:      mask = 32'h0000_2015;  // 14,5,3,1
      15:      mask = 32'h0000_6000;  // 15,14
      16:      mask = 32'h0000_D008;  // 16,15,13,4
      17:      mask = 32'h0001_2000;  // 17,14
      18:      mask = 32'h0002_0400;  // 18,11
      19:      mask = 32'h0004_0023;  // 19,6,2,1
      20:      mask = 32'h0009_0000;  // 20,17
      21:      mask = 32'h0014_0000;  // 21,19
      22:      mask = 32'h0030_0000;  // 22,21
      23:      mask = 32'h0042_0000;  // 23,18
      24:      mask = 32'h00E1_0000;  // 24,23,22,17
      25:      mask = 32'h0120_0000;  // 25,22
      26:      mask = 32'h0200_0023;  // 26,6,2,1
      27:      mask = 32'h0400_0013;  // 27,5,2,1
      28:      mask = 32'h0900_0000;  // 28,25
      29:      mask = 32'h1400_0000;  // 29,27
      30:      mask = 32'h2000_0029;  // 30,6,4,1
      31:      mask = 32'h4800_0000;  // 31,28
      32:      mask = 32'h8020_0003;  // 32,22,2,1
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/data bundle of the LFSR generator. The master drives enable, cycle
// perturbation and seed load; the slave (the generator) returns state and pulses.
interface lfsr_gen_if #(
  parameter int unsigned WID  = 17,
  parameter int unsigned STEP = 1
);

  logic            ce;
  logic            cyc;
  logic            ld;
  logic [WID-1:0]  seed;
  logic [WID-1:0]  o;
  logic [STEP-1:0] bits;
  logic            wrap;
  logic            lock;

  modport master (
    output ce, cyc, ld, seed,
    input  o, bits, wrap, lock
  );

  modport slave (
    input  ce, cyc, ld, seed,
    output o, bits, wrap, lock
  );

endinterface

// File: rtl/lfsr_step.sv
// One combinational XNOR Fibonacci shift: the feedback bit enters at bit 0.
module lfsr_step #(
  parameter int unsigned WID = 17
) (
  input  logic [WID-1:0] state,
  input  logic           cyc,
  input  logic [WID-1:0] taps,
  output logic [WID-1:0] nxt
);

  logic fb;

  // XNOR of the tapped bits, perturbed by cyc, shifted in at the bottom.
  always_comb begin
    fb  = ~((^(state & taps)) ^ cyc);
    nxt = {state[WID-2:0], fb};
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised XNOR Fibonacci LFSR with seed load, wrap pulse and STEP shifts
// per enable. Optional lock-up recovery when LFSR_LOCKUP_DETECT_EN is defined.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned    WID     = 17,
  parameter int unsigned    STEP    = 1,
  parameter logic [WID-1:0] RST_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  lfsr_gen_if.slave bus
);

  // Elaboration-time parameter range checks.
  if (WID < LFSR_MIN_WID || WID > LFSR_MAX_WID) begin : g_bad_wid
    $fatal(1, "lfsr_gen: WID out of range");
  end
  if (STEP < 1 || STEP > LFSR_MAX_STEP || STEP >= WID) begin : g_bad_step
    $fatal(1, "lfsr_gen: STEP out of range");
  end
  if (&RST_VAL) begin : g_bad_rst
    $fatal(1, "lfsr_gen: RST_VAL must not be all-ones");
  end

  localparam logic [31:0]    TapsFull = lfsr_taps(WID);
  localparam logic [WID-1:0] Taps     = TapsFull[WID-1:0];

  logic [WID-1:0] state_q, state_d;
  logic [WID-1:0] start_q, start_d;
  logic           wrap_q, wrap_d;
  logic [STEP:0][WID-1:0] chain;

  assign chain[0] = state_q;

  // STEP single-shift stages chained; every stage sees the same cyc.
  for (genvar i = 0; i < STEP; i++) begin : g_step
    lfsr_step #(
      .WID (WID)
    ) u_step (
      .state (chain[i]),
      .cyc   (bus.cyc),
      .taps  (Taps),
      .nxt   (chain[i+1])
    );
  end

`ifdef LFSR_LOCKUP_DETECT_EN
  logic lock_q, lock_d;

  // Next state: load beats lock recovery, which beats a normal advance.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    wrap_d  = 1'b0;
    lock_d  = 1'b0;
    if (bus.ld) begin
      state_d = bus.seed;
      start_d = bus.seed;
    end else if (&state_q) begin
      state_d = RST_VAL;
      lock_d  = 1'b1;
    end else if (bus.ce) begin
      state_d = chain[STEP];
      wrap_d  = (chain[STEP] == start_q);
    end
  end

  // Lock pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign bus.lock = lock_q;
`else
  // Next state: load beats a normal advance; an all-ones state stays stuck.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    wrap_d  = 1'b0;
    if (bus.ld) begin
      state_d = bus.seed;
      start_d = bus.seed;
    end else if (bus.ce) begin
      state_d = chain[STEP];
      wrap_d  = (chain[STEP] == start_q);
    end
  end

  assign bus.lock = 1'b0;
`endif

  // State, start-of-period and wrap registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_VAL;
      start_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.o    = state_q;
  assign bus.bits = state_q[STEP-1:0];
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: four configurations, scoreboard of expected
// state/wrap/lock pushed at drive time and popped after the clock edge.
module tb_lfsr_gen;

`ifdef LFSR_LOCKUP_DETECT_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  localparam int          WIDS  [4] = '{17, 17, 4, 32};
  localparam int          STEPS [4] = '{1, 4, 1, 8};
  localparam logic [31:0] MASKS [4] = '{32'h0001_2000, 32'h0001_2000, 32'h0000_000C,
                                        32'h8020_0003};

  typedef struct {
    int          c;
    logic [31:0] o;
    logic        wrap;
    logic        lock;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lfsr_gen_if #(.WID(17), .STEP(1)) if0 ();
  lfsr_gen_if #(.WID(17), .STEP(4)) if1 ();
  lfsr_gen_if #(.WID(4),  .STEP(1)) if2 ();
  lfsr_gen_if #(.WID(32), .STEP(8)) if3 ();

  lfsr_gen #(.WID(17), .STEP(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  lfsr_gen #(.WID(17), .STEP(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  lfsr_gen #(.WID(4),  .STEP(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  lfsr_gen #(.WID(32), .STEP(8)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wrap_seen = 0;
  exp_t        sb[$];
  logic [31:0] mstate[4];
  logic [31:0] mstart[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mstep(input logic [31:0] s, input int w,
                                        input logic [31:0] m, input bit cy);
    logic [63:0] ones;
    logic        fb;
    ones = (64'd1 << w) - 64'd1;
    fb   = ~((^(s & m)) ^ cy);
    return ((s << 1) | {31'd0, fb}) & ones[31:0];
  endfunction

  task automatic drive(input int c, input bit ce, input bit cy, input bit ld,
                       input logic [31:0] seed);
    case (c)
      0: begin if0.ce = ce; if0.cyc = cy; if0.ld = ld; if0.seed = seed[16:0]; end
      1: begin if1.ce = ce; if1.cyc = cy; if1.ld = ld; if1.seed = seed[16:0]; end
      2: begin if2.ce = ce; if2.cyc = cy; if2.ld = ld; if2.seed = seed[3:0]; end
      default: begin if3.ce = ce; if3.cyc = cy; if3.ld = ld; if3.seed = seed; end
    endcase
  endtask

  task automatic observe(input int c, output logic [31:0] o, output logic [31:0] b,
                         output logic w, output logic l);
    case (c)
      0: begin o = 32'(if0.o); b = 32'(if0.bits); w = if0.wrap; l = if0.lock; end
      1: begin o = 32'(if1.o); b = 32'(if1.bits); w = if1.wrap; l = if1.lock; end
      2: begin o = 32'(if2.o); b = 32'(if2.bits); w = if2.wrap; l = if2.lock; end
      default: begin o = if3.o; b = 32'(if3.bits); w = if3.wrap; l = if3.lock; end
    endcase
  endtask

  // One clock of stimulus on config c; expectation computed from the model.
  task automatic tick(input int c, input bit ce, input bit cy, input bit ld,
                      input logic [31:0] seed);
    exp_t        e;
    logic [63:0] ones;
    logic [31:0] st, o, b, bmask;
    logic        w, l;
    ones   = (64'd1 << WIDS[c]) - 64'd1;
    st     = mstate[c];
    e.c    = c;
    e.wrap = 1'b0;
    e.lock = 1'b0;
    drive(c, ce, cy, ld, seed);
    if (ld) begin
      st        = seed & ones[31:0];
      mstart[c] = st;
    end else if (LockEn && st == ones[31:0]) begin
      st     = '0;
      e.lock = 1'b1;
    end else if (ce) begin
      for (int k = 0; k < STEPS[c]; k++) st = mstep(st, WIDS[c], MASKS[c], cy);
      e.wrap = (st == mstart[c]);
    end
    mstate[c] = st;
    e.o       = st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive(c, 1'b0, 1'b0, 1'b0, 32'd0);
    observe(c, o, b, w, l);
    if (w && c == 2) wrap_seen++;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e     = sb.pop_front();
      bmask = (32'd1 << STEPS[e.c]) - 32'd1;
      check_eq($sformatf("c%0d_o", e.c), o, e.o);
      check_eq($sformatf("c%0d_bits", e.c), b, e.o & bmask);
      check_eq($sformatf("c%0d_wrap", e.c), {31'd0, w}, {31'd0, e.wrap});
      check_eq($sformatf("c%0d_lock", e.c), {31'd0, l}, {31'd0, e.lock});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mstate[i] = '0;
      mstart[i] = '0;
    end
  endtask

  initial begin
    logic [31:0] o, b;
    logic        w, l;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 1'b0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      observe(i, o, b, w, l);
      check_eq($sformatf("rst_c%0d_o", i), o, 32'd0);
      check_eq($sformatf("rst_c%0d_wrap", i), {31'd0, w}, 32'd0);
      check_eq($sformatf("rst_c%0d_lock", i), {31'd0, l}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // WID=17 STEP=1: 1, 3, 7 from reset
    for (int i = 0; i < 3; i++) tick(0, 1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("w17_third", mstate[0], 32'h0000_0007);
    // cyc=1 from zero keeps zero; load wins over ce
    tick(0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick(0, 1'b1, 1'b1, 1'b0, 32'd0);
    tick(0, 1'b1, 1'b0, 1'b1, 32'h0000_0ABC);
    for (int i = 0; i < 6; i++) tick(0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
    // all-ones seed: recovered with lock pulse, or stuck without detection
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0001_FFFF);
    tick(0, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(0, 1'b0, 1'b0, 1'b0, 32'd0);

    // WID=17 STEP=4: one enable gives 0xF, then holds
    tick(1, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) tick(1, 1'b0, 1'b0, 1'b0, 32'd0);

    // WID=4: full period twice
    for (int i = 0; i < 30; i++) tick(2, 1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("w4_wrap_count", 32'(wrap_seen), 32'd2);

    // WID=32 STEP=8: ten enables, then asynchronous reset mid-cycle
    for (int i = 0; i < 10; i++) tick(3, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
    drive(3, 1'b1, 1'b0, 1'b0, 32'd0);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    observe(3, o, b, w, l);
    check_eq("async_rst_o", o, 32'd0);
    check_eq("async_rst_wrap", {31'd0, w}, 32'd0);
    @(posedge clk);
    #1;
    observe(3, o, b, w, l);
    check_eq("rst_held_o", o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(3, 1'b1, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
